// File: rtl/bus_rr_router.sv
// Packet router: arbitrates among DRVRS show-ahead FIFOs, pops one head word and
// pushes it to its destination(s). Optional drop counter enabled by BUS_RR_DROP_CNT_EN.
module bus_rr_router #(
  parameter int DRVRS = 4,
  parameter int PCKG_SZ = 32,
  parameter int ID_W = 8,
  parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}},
  parameter int ARB_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DRVRS-1:0]         pndng,
  input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
  output logic [DRVRS-1:0]         pop,
  output logic [DRVRS-1:0]         push,
  output logic [DRVRS*PCKG_SZ-1:0] D_push,
  output logic [15:0]              drop_cnt
);

  localparam int SRC_W = (DRVRS > 1) ? $clog2(DRVRS) : 1;

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t             state;
  logic [PCKG_SZ-1:0] pkt_q;
  logic [SRC_W-1:0]   src_q;
  logic [SRC_W-1:0]   last_winner;
  logic [SRC_W-1:0]   win;
  logic               any;
  logic [DRVRS-1:0]   push_mask;
  logic [ID_W-1:0]    dest;
  int                 dest_i;
  int                 src_i;
  logic [PCKG_SZ-1:0] heads [DRVRS];

  for (genvar g = 0; g < DRVRS; g++) begin : g_heads
    assign heads[g] = D_pop[g*PCKG_SZ +: PCKG_SZ];
  end

  // Round-robin search starts just after the previous winner.
  always_comb begin
    win = '0;
    any = 1'b0;
    if (ARB_MODE == 1) begin
      for (int i = DRVRS - 1; i >= 0; i--) begin
        if (pndng[i[SRC_W-1:0]]) begin
          win = i[SRC_W-1:0];
          any = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < DRVRS; k++) begin
        int idx;
        idx = (int'(last_winner) + 1 + k) % DRVRS;
        if (!any && pndng[idx[SRC_W-1:0]]) begin
          win = idx[SRC_W-1:0];
          any = 1'b1;
        end
      end
    end
  end

  // An all-zero mask means the packet is dropped.
  always_comb begin
    dest      = pkt_q[PCKG_SZ-1 -: ID_W];
    dest_i    = int'(dest);
    src_i     = int'(src_q);
    push_mask = '0;
    if (dest == BROADCAST)
      push_mask = ~(DRVRS'(1) << src_i);
    else if (dest_i < DRVRS && dest_i != src_i)
      push_mask = DRVRS'(1) << dest_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pop         <= '0;
      push        <= '0;
      D_push      <= '0;
      pkt_q       <= '0;
      src_q       <= '0;
      last_winner <= SRC_W'(DRVRS - 1);
    end else begin
      pop  <= '0;
      push <= '0;
      case (state)
        POP: begin
          push   <= push_mask;
          D_push <= {DRVRS{pkt_q}};
          state  <= PUSH;
        end
        default: begin
          if (any) begin
            pop         <= DRVRS'(1) << win;
            pkt_q       <= heads[win];
            src_q       <= win;
            last_winner <= win;
            state       <= POP;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef BUS_RR_DROP_CNT_EN
  logic drop_now;
  assign drop_now = (state == POP) && (push_mask == '0);

  always_ff @(posedge clk) begin
    if (reset)
      drop_cnt <= '0;
    else if (drop_now && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_rr_router.sv
// Directed bench for bus_rr_router: round-robin and fixed-priority instances
// driven side by side, single-packet vector table plus multi-cycle sequences.
module tb_bus_rr_router;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   pndng, pndng_fp_own, pndng_fp;
  logic         use_fp_own;
  logic [127:0] d_pop;
  logic [3:0]   pop_rr, push_rr, pop_fp, push_fp;
  logic [127:0] d_push_rr, d_push_fp;
  logic [15:0]  drop_rr, drop_fp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign pndng_fp = use_fp_own ? pndng_fp_own : pndng;

  bus_rr_router #(.ARB_MODE(0)) dut_rr (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop),
    .pop(pop_rr), .push(push_rr), .D_push(d_push_rr), .drop_cnt(drop_rr)
  );

  bus_rr_router #(.ARB_MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .pndng(pndng_fp), .D_pop(d_pop),
    .pop(pop_fp), .push(push_fp), .D_push(d_push_fp), .drop_cnt(drop_fp)
  );

  typedef struct {
    int          src;
    logic [31:0] pkt;
    logic [3:0]  exp_pop;
    logic [3:0]  exp_push;
  } vec_t;

  vec_t vecs[8];

`ifdef BUS_RR_DROP_CNT_EN
  localparam logic [15:0] EXP_DROPS = 16'd3;
`else
  localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    logic [3:0] rr_order [5];
    logic [3:0] rr_push  [5];

    vecs[0] = '{1, 32'h02AB_CDEF, 4'b0010, 4'b0100};
    vecs[1] = '{2, 32'hFF00_1234, 4'b0100, 4'b1011};
    vecs[2] = '{0, 32'h0300_0000, 4'b0001, 4'b1000};
    vecs[3] = '{3, 32'h00FF_FFFF, 4'b1000, 4'b0001};
    vecs[4] = '{0, 32'h0700_0000, 4'b0001, 4'b0000};
    vecs[5] = '{2, 32'h0200_0055, 4'b0100, 4'b0000};
    vecs[6] = '{3, 32'hFF00_ABCD, 4'b1000, 4'b0111};
    vecs[7] = '{0, 32'h0400_0000, 4'b0001, 4'b0000};

    rr_order[0] = 4'b0001; rr_order[1] = 4'b0010; rr_order[2] = 4'b0100;
    rr_order[3] = 4'b1000; rr_order[4] = 4'b0001;
    rr_push[0] = 4'b0010; rr_push[1] = 4'b0000; rr_push[2] = 4'b0010;
    rr_push[3] = 4'b0010; rr_push[4] = 4'b0010;

    reset = 1'b1;
    pndng = '0;
    pndng_fp_own = '0;
    use_fp_own = 1'b0;
    d_pop = '0;
    step();
    step();
    chk("reset_pop", 128'(pop_rr), 128'(4'b0000));
    chk("reset_push", 128'(push_rr), 128'(4'b0000));
    chk("reset_dpush", d_push_rr, 128'h0);
    chk("reset_drop", 128'(drop_rr), 128'h0);
    reset = 1'b0;
    step();
    chk("idle_pop", 128'(pop_rr), 128'(4'b0000));

    for (int v = 0; v < 8; v++) begin
      d_pop = '0;
      d_pop[vecs[v].src*32 +: 32] = vecs[v].pkt;
      pndng = 4'(1 << vecs[v].src);
      step();
      chk($sformatf("v%0d_pop", v), 128'(pop_rr), 128'(vecs[v].exp_pop));
      chk($sformatf("v%0d_push_in_pop", v), 128'(push_rr), 128'(4'b0000));
      pndng = '0;
      step();
      chk($sformatf("v%0d_pop_in_push", v), 128'(pop_rr), 128'(4'b0000));
      chk($sformatf("v%0d_push", v), 128'(push_rr), 128'(vecs[v].exp_push));
      chk($sformatf("v%0d_push_fp", v), 128'(push_fp), 128'(vecs[v].exp_push));
      chk($sformatf("v%0d_dpush", v), d_push_rr, {4{vecs[v].pkt}});
      step();
      chk($sformatf("v%0d_push_after", v), 128'(push_rr), 128'(4'b0000));
    end
    chk("drop_cnt", 128'(drop_rr), 128'(EXP_DROPS));

    // Reset during the POP cycle must abort the transfer.
    d_pop = '0;
    d_pop[2*32 +: 32] = 32'h0000_0000;
    pndng = 4'b0100;
    step();
    chk("mid_pop", 128'(pop_rr), 128'(4'b0100));
    reset = 1'b1;
    pndng = '0;
    step();
    chk("mid_reset_pop", 128'(pop_rr), 128'(4'b0000));
    chk("mid_reset_push", 128'(push_rr), 128'(4'b0000));
    chk("mid_reset_drop", 128'(drop_rr), 128'h0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("mid_no_push%0d", c), 128'(push_rr), 128'(4'b0000));
    end
    pndng = 4'b1101;
    step();
    chk("mid_next_grant", 128'(pop_rr), 128'(4'b0001));
    pndng = '0;
    step();
    step();

    // Continuous requests: round-robin rotates, fixed priority sticks to device 0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    d_pop = {4{32'h0100_0000}};
    pndng = 4'b1111;
    pndng_fp_own = 4'b1001;
    use_fp_own = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k % 2 == 0) begin
        chk($sformatf("rr_pop%0d", k), 128'(pop_rr), 128'(rr_order[k/2]));
        chk($sformatf("fp_pop%0d", k), 128'(pop_fp), 128'(4'b0001));
        chk($sformatf("rr_push_idle%0d", k), 128'(push_rr), 128'(4'b0000));
      end else begin
        chk($sformatf("rr_gap%0d", k), 128'(pop_rr), 128'(4'b0000));
        chk($sformatf("rr_push%0d", k), 128'(push_rr), 128'(rr_push[k/2]));
        chk($sformatf("fp_push%0d", k), 128'(push_fp), 128'(4'b0010));
      end
    end
    pndng = '0;
    use_fp_own = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_rr_router.md
BUS_RR_ROUTER -- requirements
Module: bus_rr_router

Interface
REQ-001 Parameter DRVRS, default 4: number of attached devices, 2..16.
REQ-002 Parameter PCKG_SZ, default 32: packet width in bits, greater than ID_W.
REQ-003 Parameter ID_W, default 8: destination-ID field width, taken from packet bits [PCKG_SZ-1 -: ID_W].
REQ-004 Parameter BROADCAST, default {ID_W{1'b1}}: destination ID meaning "all devices".
REQ-005 Parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-006 clk  input  1: single clock; all logic SHALL be synchronous to its rising edge.
REQ-007 reset  input  1: synchronous, active-high reset.
REQ-008 pndng  input  DRVRS: bit i high means the source FIFO of device i is non-empty.
REQ-009 D_pop  input  DRVRS*PCKG_SZ: slice i is the show-ahead head word of device i, valid while pndng[i] is high.
REQ-010 pop  output  DRVRS: one-cycle pulse that consumes the head word of device i.
REQ-011 push  output  DRVRS: one-cycle pulse that writes D_push into device i.
REQ-012 D_push  output  DRVRS*PCKG_SZ: every slice SHALL carry the same latched packet.
REQ-013 drop_cnt  output  16: count of dropped packets (see Configuration).

Function
REQ-014 The block SHALL use a three-state FSM with states IDLE, POP and PUSH; all outputs SHALL be registered.
REQ-015 IDLE: if pndng is non-zero, the block SHALL select winner w, then on the next edge set pop[w]=1, latch pkt_q<=D_pop[w] and src_q<=w, and go to POP; otherwise it SHALL stay in IDLE.
REQ-016 POP: the block SHALL hold pop at 1 for exactly one cycle, then unconditionally go to PUSH with pop=0.
REQ-017 PUSH: push SHALL be asserted for exactly one cycle per the destination rules, with D_push = pkt_q.
REQ-018 PUSH arbitration: from PUSH the block SHALL arbitrate exactly as in IDLE and go to POP if pndng is non-zero, otherwise to IDLE.
REQ-019 Throughput and latency: sustained throughput SHALL be one packet per 2 cycles; pop SHALL rise 1 cycle and push 2 cycles after the cycle in which pndng is sampled.
REQ-020 Round-robin (ARB_MODE=0): the search SHALL start at (last_winner+1) mod DRVRS; last_winner SHALL update only on a grant.
REQ-021 Fixed priority (ARB_MODE=1): the lowest index with pndng set SHALL win.
REQ-022 Destination, broadcast: if dest == BROADCAST, push SHALL be asserted for all devices except src_q.
REQ-023 Destination, unicast: if dest < DRVRS and dest != src_q, only push[dest] SHALL be asserted.
REQ-024 Destination, drop: if dest >= DRVRS (and not BROADCAST) or dest == src_q, the packet SHALL be dropped: PUSH state is still taken with push = 0.
REQ-025 A device whose packet is in flight SHALL remain eligible in the PUSH-state arbitration; its updated pndng is valid in that cycle.
REQ-026 pop and push SHALL never both be non-zero in the same cycle.
REQ-027 pop SHALL never have more than one bit set.

Reset
REQ-028 While reset is high at a rising edge, the block SHALL set state=IDLE, pop=0, push=0, D_push=0, pkt_q=0, src_q=0, last_winner=DRVRS-1 and drop_cnt=0.
REQ-029 Reset in POP or PUSH SHALL abort the transfer: the popped packet is lost and no push is issued afterwards.
REQ-030 The first grant after reset in round-robin mode SHALL go to the lowest-index pending device.

Configuration
REQ-031 Macro BUS_RR_DROP_CNT_EN defined: drop_cnt SHALL increment by 1 on every dropped packet (REQ-024), saturating at 16'hFFFF.
REQ-032 Macro BUS_RR_DROP_CNT_EN undefined: drop_cnt SHALL be tied to 0 and no counter logic SHALL be synthesised.

Verification
REQ-033 Scenario, unicast: DRVRS=4; device 1 pending with 32'h02AB_CDEF -> pop[1] for 1 cycle, next cycle push=4'b0100 with D_push=32'h02AB_CDEF.
REQ-034 Scenario, broadcast: device 2 sends 32'hFF00_1234 -> push=4'b1011, all slices equal to 32'hFF00_1234.
REQ-035 Scenario, round-robin: ARB_MODE=0, devices 0-3 each continuously pending -> grant order 0,1,2,3,0, one pop every 2 cycles.
REQ-036 Scenario, fixed priority: ARB_MODE=1, devices 0 and 3 continuously pending -> device 0 wins every grant.
REQ-037 Scenario, drops: packets with dest 8'h07 and dest == source -> push stays 0 in PUSH; drop_cnt reaches 2 with BUS_RR_DROP_CNT_EN defined, 0 without.
REQ-038 Scenario, reset mid-transfer: reset asserted in the POP cycle -> push never asserts; next grant goes to device 0.
